// File: rtl/qpsk_demap.sv
// qpsk_demap: hard-decision QPSK slicer, packs 4 symbols per output byte.
// Ports: stream in DAT_I[31:0]={Im,Re}, CYC_I/STB_I/WE_I, ACK_O (comb);
//   stream out DAT_O[7:0], CYC_O/STB_O (reg), WE_O=STB_O, ACK_I.
//   CLK_I posedge, RST_I synchronous active-high.
// Option: QPSK_DEMAP_FLUSH_EN emits a zero-padded partial byte at
//   end of packet instead of discarding it.
module qpsk_demap (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [31:0] DAT_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  output logic        ACK_O,
  output logic [7:0]  DAT_O,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  input  logic        ACK_I
);

  logic [1:0] cnt;
  logic [5:0] acc;
  logic       icyc;
  logic       flush_pend;
  logic       out_halt;
  logic       ena;
  logic       eop;
  logic       part;
  logic       last;
  logic       flush_go;
  logic       drop;
  logic       load;
  logic [1:0] pair;
  logic [7:0] load_dat;

  assign out_halt = STB_O & ~ACK_I;
  assign ena      = CYC_I & STB_I & WE_I;
  // sign slice: non-negative component decides 1
  assign pair     = {~DAT_I[31], ~DAT_I[15]};
  assign eop      = icyc & ~CYC_I;
  assign part     = (cnt != 2'd0);
  assign WE_O     = STB_O;

`ifdef QPSK_DEMAP_FLUSH_EN
  // a stalled flush beat must leave before a new packet fills acc
  assign ACK_O    = ena & ~out_halt & ~flush_pend;
  assign flush_go = ((eop & part) | flush_pend) & ~out_halt;
  assign drop     = 1'b0;

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      flush_pend <= 1'b0;
    end else if (flush_go) begin
      flush_pend <= 1'b0;
    end else if (eop & part) begin
      flush_pend <= 1'b1;
    end
  end
`else
  assign ACK_O      = ena & ~out_halt;
  assign flush_go   = 1'b0;
  assign drop       = eop & part;
  assign flush_pend = 1'b0;
`endif

  assign last     = ACK_O & (cnt == 2'd3);
  assign load     = last | flush_go;
  // unfilled slots of acc are already zero
  assign load_dat = last ? {pair, acc} : {2'b00, acc};

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      icyc  <= 1'b0;
      cnt   <= 2'd0;
      acc   <= 6'd0;
      DAT_O <= 8'h00;
      STB_O <= 1'b0;
      CYC_O <= 1'b0;
    end else begin
      icyc <= CYC_I;

      if (load) begin
        DAT_O <= load_dat;
        STB_O <= 1'b1;
      end else if (STB_O & ACK_I) begin
        STB_O <= 1'b0;
      end

      if (load | drop) begin
        cnt <= 2'd0;
        acc <= 6'd0;
      end else if (ACK_O) begin
        cnt <= cnt + 2'd1;
        unique case (1'b1)
          (cnt == 2'd0): acc[1:0] <= pair;
          (cnt == 2'd1): acc[3:2] <= pair;
          (cnt == 2'd2): acc[5:4] <= pair;
          default:       acc      <= acc;
        endcase
      end

      if (CYC_I) begin
        CYC_O <= 1'b1;
      end else if (~STB_O & ~part & ~flush_pend) begin
        CYC_O <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qpsk_demap.sv
// tb_qpsk_demap: scoreboard bench for qpsk_demap.
// Expected bytes are queued as symbols are accepted, checked on output.
`timescale 1ns/1ps
module tb_qpsk_demap;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic [31:0] DAT_I = '0;
  logic        CYC_I = 1'b0;
  logic        STB_I = 1'b0;
  logic        WE_I  = 1'b0;
  logic        ACK_O;
  logic [7:0]  DAT_O;
  logic        CYC_O;
  logic        STB_O;
  logic        WE_O;
  logic        ACK_I = 1'b1;

  int tests = 0;
  int fails = 0;
  int beats = 0;
  int stb_cycles = 0;
  int waits = 0;

  logic [7:0] exp_q[$];
  int         mcnt = 0;
  logic [7:0] mbyte = 8'h00;

  always #5 CLK_I = ~CLK_I;

  qpsk_demap dut (
    .CLK_I(CLK_I),
    .RST_I(RST_I),
    .DAT_I(DAT_I),
    .CYC_I(CYC_I),
    .STB_I(STB_I),
    .WE_I (WE_I),
    .ACK_O(ACK_O),
    .DAT_O(DAT_O),
    .CYC_O(CYC_O),
    .STB_O(STB_O),
    .WE_O (WE_O),
    .ACK_I(ACK_I)
  );

  function automatic void model_clear();
    mcnt  = 0;
    mbyte = 8'h00;
    exp_q.delete();
  endfunction

  function automatic void model_sym(input logic [31:0] d);
    logic [7:0] p;
    p = 8'h00;
    p[0] = ($signed(d[15:0]) >= 0);
    p[1] = ($signed(d[31:16]) >= 0);
    mbyte = mbyte | (p << (2 * mcnt));
    mcnt++;
    if (mcnt == 4) begin
      exp_q.push_back(mbyte);
      mcnt  = 0;
      mbyte = 8'h00;
    end
  endfunction

  function automatic void model_eop();
    if (mcnt != 0) begin
`ifdef QPSK_DEMAP_FLUSH_EN
      exp_q.push_back(mbyte);
`endif
      mcnt  = 0;
      mbyte = 8'h00;
    end
  endfunction

  // output monitor: a beat transfers on the edge after STB_O & ACK_I
  always @(negedge CLK_I) begin
    if (!RST_I && STB_O) stb_cycles++;
    if (!RST_I && STB_O && ACK_I) begin
      logic [7:0] e;
      beats++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL beat_extra: got %h want none", DAT_O);
      end else begin
        e = exp_q.pop_front();
        if (DAT_O !== e) begin
          fails++;
          $display("FAIL beat_data: got %h want %h", DAT_O, e);
        end
      end
    end
  end

  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    DAT_I = d;
    CYC_I = 1'b1;
    STB_I = 1'b1;
    WE_I  = 1'b1;
    @(negedge CLK_I);
    while (ACK_O !== 1'b1 && n < 200) begin
      @(negedge CLK_I);
      n++;
    end
    waits += n;
    tests++;
    if (ACK_O !== 1'b1) begin
      fails++;
      $display("FAIL ack_timeout: got %b want 1", ACK_O);
    end else begin
      model_sym(d);
    end
    @(posedge CLK_I);
    #1;
    STB_I = 1'b0;
  endtask

  task automatic end_pkt();
    CYC_I = 1'b0;
    STB_I = 1'b0;
    WE_I  = 1'b0;
    model_eop();
    repeat (4) @(posedge CLK_I);
    #1;
  endtask

  task automatic test_reset();
    RST_I = 1'b1;
    repeat (2) @(posedge CLK_I);
    @(negedge CLK_I);
    tests++;
    if (DAT_O !== 8'h00) begin
      fails++;
      $display("FAIL reset_dat: got %h want 00", DAT_O);
    end
    tests++;
    if (STB_O !== 1'b0) begin
      fails++;
      $display("FAIL reset_stb: got %b want 0", STB_O);
    end
    tests++;
    if (CYC_O !== 1'b0) begin
      fails++;
      $display("FAIL reset_cyc: got %b want 0", CYC_O);
    end
    tests++;
    if (WE_O !== 1'b0) begin
      fails++;
      $display("FAIL reset_we: got %b want 0", WE_O);
    end
    @(posedge CLK_I);
    #1;
    RST_I = 1'b0;
    model_clear();
  endtask

  task automatic test_basic();
    int w0;
    ACK_I = 1'b1;
    w0 = waits;
    send(32'h5A82_5A82);
    send(32'hA57E_5A82);
    send(32'h5A82_A57E);
    send(32'hA57E_A57E);
    tests++;
    if (waits - w0 != 0) begin
      fails++;
      $display("FAIL basic_ack: got %0d stalls want 0", waits - w0);
    end
    tests++;
    if (STB_O !== 1'b1 || DAT_O !== 8'h27) begin
      fails++;
      $display("FAIL basic_latency: got stb=%b dat=%h want 1 27",
               STB_O, DAT_O);
    end
    @(posedge CLK_I);
    #1;
    tests++;
    if (STB_O !== 1'b0) begin
      fails++;
      $display("FAIL basic_one_cycle: got %b want 0", STB_O);
    end
    end_pkt();
    tests++;
    if (CYC_O !== 1'b0) begin
      fails++;
      $display("FAIL basic_cyc_end: got %b want 0", CYC_O);
    end
  endtask

  task automatic test_zero();
    ACK_I = 1'b1;
    repeat (4) send(32'h0000_0000);
    end_pkt();
  endtask

  task automatic test_backpressure();
    int b0;
    int bad;
    b0  = beats;
    bad = 0;
    ACK_I = 1'b0;
    send(32'h5A82_5A82);
    send(32'hA57E_5A82);
    send(32'h5A82_A57E);
    send(32'hA57E_A57E);
    fork
      begin
        for (int i = 0; i < 8; i++) send($urandom);
      end
      begin
        repeat (10) begin
          @(negedge CLK_I);
          if (ACK_O !== 1'b0 || DAT_O !== 8'h27 || STB_O !== 1'b1)
            bad++;
        end
        @(posedge CLK_I);
        #1;
        ACK_I = 1'b1;
      end
    join
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bp_hold: got %0d bad cycles want 0", bad);
    end
    end_pkt();
    tests++;
    if (beats - b0 != 3 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL bp_count: got %0d beats %0d left want 3 0",
               beats - b0, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int b0;
    int s0;
    int w0;
    ACK_I = 1'b1;
    b0 = beats;
    s0 = stb_cycles;
    w0 = waits;
    for (int k = 0; k < 4; k++) begin
      repeat (4) send((k % 2 == 0) ? 32'h0000_0000 : 32'hA57E_A57E);
    end
    end_pkt();
    tests++;
    if (beats - b0 != 4 || stb_cycles - s0 != 4) begin
      fails++;
      $display("FAIL b2b_beats: got %0d/%0d want 4/4",
               beats - b0, stb_cycles - s0);
    end
    tests++;
    if (waits - w0 != 0) begin
      fails++;
      $display("FAIL b2b_rate: got %0d stalls want 0", waits - w0);
    end
  endtask

  task automatic test_partial();
    int b0;
    int want;
    ACK_I = 1'b1;
    b0 = beats;
    send(32'h5A82_5A82);
    send(32'h5A82_5A82);
    CYC_I = 1'b0;
    STB_I = 1'b0;
    WE_I  = 1'b0;
    model_eop();
    @(negedge CLK_I);
    @(negedge CLK_I);
`ifdef QPSK_DEMAP_FLUSH_EN
    want = 1;
    tests++;
    if (STB_O !== 1'b1 || DAT_O !== 8'h0F) begin
      fails++;
      $display("FAIL flush_beat: got stb=%b dat=%h want 1 0f",
               STB_O, DAT_O);
    end
    @(negedge CLK_I);
    tests++;
    if (STB_O !== 1'b0 || CYC_O !== 1'b1) begin
      fails++;
      $display("FAIL flush_after: got stb=%b cyc=%b want 0 1",
               STB_O, CYC_O);
    end
    @(negedge CLK_I);
`else
    want = 0;
    tests++;
    if (CYC_O !== 1'b1 || STB_O !== 1'b0) begin
      fails++;
      $display("FAIL drop_hold: got cyc=%b stb=%b want 1 0",
               CYC_O, STB_O);
    end
    @(negedge CLK_I);
`endif
    tests++;
    if (CYC_O !== 1'b0) begin
      fails++;
      $display("FAIL partial_cyc: got %b want 0", CYC_O);
    end
    repeat (3) @(posedge CLK_I);
    #1;
    tests++;
    if (beats - b0 != want) begin
      fails++;
      $display("FAIL partial_beats: got %0d want %0d", beats - b0, want);
    end
  endtask

  task automatic test_reset_mid();
    int b0;
    ACK_I = 1'b1;
    repeat (3) send(32'h5A82_5A82);
    RST_I = 1'b1;
    CYC_I = 1'b0;
    STB_I = 1'b0;
    WE_I  = 1'b0;
    @(posedge CLK_I);
    @(negedge CLK_I);
    tests++;
    if (DAT_O !== 8'h00 || STB_O !== 1'b0 || CYC_O !== 1'b0 ||
        WE_O !== 1'b0 || ACK_O !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_out: got dat=%h stb=%b cyc=%b we=%b ack=%b",
               DAT_O, STB_O, CYC_O, WE_O, ACK_O);
    end
    model_clear();
    @(posedge CLK_I);
    #1;
    RST_I = 1'b0;
    b0 = beats;
    repeat (4) send(32'hA57E_A57E);
    end_pkt();
    tests++;
    if (beats - b0 != 1) begin
      fails++;
      $display("FAIL mid_reset_beats: got %0d want 1", beats - b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_partial();
    test_reset_mid();
    repeat (4) @(posedge CLK_I);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover: got %0d bytes want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
